// File: rtl/keypad_digit_entry_pkg.sv
// Shared definitions for the keypad digit entry block: PS/2 set-2 scan codes,
// the entry state machine encoding and the blank nibble code.
package keypad_digit_entry_pkg;

  // Digits held in the entry buffer (tied to the 16-bit nums bus)
  localparam int NUM_DIGITS = 4;

  // Nibble shown for an unused digit position; the display blanks anything above 9
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Numpad digit scan codes, element [d] is the code for digit d
  localparam logic [9:0][7:0] SC_KP_DIGITS = {
    8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70
  };

  // Top-row digit scan codes, element [d] is the code for digit d
  localparam logic [9:0][7:0] SC_TR_DIGITS = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

  // Control keys
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ENTRY,
    ST_FULL,
    ST_SHOW
  } entry_state_t;

  // Decoded meaning of one scan code
  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
    logic       is_commit;
    logic       is_bksp;
    logic       is_clr;
  } key_info_t;

endpackage

// File: rtl/keypad_digit_entry_key_code_to_bcd.sv
// Combinational scan-code classifier for the keypad digit entry block.
// Define KEYPAD_TOPROW_EN to accept the top-row number keys as digits in
// addition to the numpad.
module key_code_to_bcd
  import keypad_digit_entry_pkg::*;
(
  input  logic [8:0] code,
  output key_info_t  info
);

  logic       std_code;
  logic [9:0] kp_hit;
  logic [9:0] tr_hit;
  logic [9:0] digit_hit;

  // Extended codes (E0 prefix) never map to anything this block cares about
  assign std_code = ~code[8];

  // One comparator per digit for each key group
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_digit_match
      assign kp_hit[gi] = (code[7:0] == SC_KP_DIGITS[gi]);
`ifdef KEYPAD_TOPROW_EN
      assign tr_hit[gi] = (code[7:0] == SC_TR_DIGITS[gi]);
`else
      assign tr_hit[gi] = 1'b0;
`endif
    end
  endgenerate

  assign digit_hit = kp_hit | tr_hit;

  // Collapse the match vectors into the decoded key record
  always_comb begin
    info           = '0;
    info.is_digit  = std_code && (|digit_hit);
    for (int i = 0; i < 10; i++) begin
      if (digit_hit[i]) info.digit = 4'(i);
    end
    info.is_commit = std_code && (code[7:0] == SC_SPACE);
    info.is_bksp   = std_code && (code[7:0] == SC_BKSP);
    info.is_clr    = std_code && (code[7:0] == SC_ESC);
  end

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad digit entry: turns PS/2 key presses into a 4-digit BCD entry buffer
// with backspace, clear (ESC) and commit (SPACE). Optional build macro
// KEYPAD_TOPROW_EN also accepts the top-row number keys as digits.
module keypad_digit_entry
  import keypad_digit_entry_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic [15:0]  nums,
  output logic [15:0]  value,
  output logic         commit,
  output logic [2:0]   digit_count,
  output logic         overflow
);

  entry_state_t state_reg;
  logic [15:0]  nums_reg;
  logic [15:0]  value_reg;
  logic         commit_reg;
  logic [2:0]   count_reg;
  logic         overflow_reg;

  logic         press;
  key_info_t    key;
  logic [15:0]  value_next;

  // Only make events count; the decoder has already updated key_down
  assign press = en && key_valid && key_down[last_change];

  key_code_to_bcd u_decode (
    .code (last_change),
    .info (key)
  );

  // Committed value: blank positions read as leading zeros
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_commit_nibble
      assign value_next[gi*4 +: 4] =
        (nums_reg[gi*4 +: 4] == BLANK_CODE) ? 4'h0 : nums_reg[gi*4 +: 4];
    end
  endgenerate

  // Entry state machine, buffer and pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      nums_reg     <= {NUM_DIGITS{BLANK_CODE}};
      value_reg    <= '0;
      commit_reg   <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      // Pulses last one cycle regardless of en
      commit_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      if (press) begin
        if (key.is_clr) begin
          nums_reg  <= {NUM_DIGITS{BLANK_CODE}};
          count_reg <= '0;
          state_reg <= ST_EMPTY;
        end else if (key.is_digit) begin
          case (state_reg)
            ST_EMPTY, ST_SHOW: begin
              nums_reg  <= {BLANK_CODE, BLANK_CODE, BLANK_CODE, key.digit};
              count_reg <= 3'd1;
              state_reg <= ST_ENTRY;
            end
            ST_ENTRY: begin
              nums_reg  <= {nums_reg[11:0], key.digit};
              count_reg <= count_reg + 3'd1;
              if (count_reg + 3'd1 == 3'(NUM_DIGITS)) state_reg <= ST_FULL;
            end
            default: begin
              overflow_reg <= 1'b1;
            end
          endcase
        end else if (key.is_bksp) begin
          if (state_reg == ST_ENTRY || state_reg == ST_FULL) begin
            nums_reg  <= {BLANK_CODE, nums_reg[15:4]};
            count_reg <= count_reg - 3'd1;
            state_reg <= (count_reg == 3'd1) ? ST_EMPTY : ST_ENTRY;
          end
        end else if (key.is_commit) begin
          if (state_reg == ST_ENTRY || state_reg == ST_FULL) begin
            value_reg  <= value_next;
            commit_reg <= 1'b1;
            count_reg  <= '0;
            state_reg  <= ST_SHOW;
          end
        end
      end
    end
  end

  assign nums        = nums_reg;
  assign value       = value_reg;
  assign commit      = commit_reg;
  assign digit_count = count_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry: directed scenarios plus a
// randomized key stream checked against a queue-based reference model.
module tb_keypad_digit_entry;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic [15:0]  nums;
  logic [15:0]  value;
  logic         commit;
  logic [2:0]   digit_count;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: entered digits in typing order, plus "showing committed" flag
  int          mq[$];
  bit          m_show;
  logic [15:0] m_value;
  bit          exp_commit;
  bit          exp_ovf;

  int kp_codes[10] = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};
  int tr_codes[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};

  keypad_digit_entry dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .nums        (nums),
    .value       (value),
    .commit      (commit),
    .digit_count (digit_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] kp(input int d);
    return {1'b0, 8'(kp_codes[d])};
  endfunction

  function automatic logic [8:0] tr(input int d);
    return {1'b0, 8'(tr_codes[d])};
  endfunction

  // Digit value of a scan code, or -1 when it is not an accepted digit key
  function automatic int digit_of(input logic [8:0] c);
    if (c[8]) return -1;
    for (int i = 0; i < 10; i++) begin
      if (int'(c[7:0]) == kp_codes[i]) return i;
`ifdef KEYPAD_TOPROW_EN
      if (int'(c[7:0]) == tr_codes[i]) return i;
`endif
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_nums();
    logic [15:0] r;
    int n;
    int t;
    r = 16'hFFFF;
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      t = mq[n-1-i];
      r[4*i +: 4] = t[3:0];
    end
    return r;
  endfunction

  function automatic logic [2:0] model_count();
    return m_show ? 3'd0 : 3'(mq.size());
  endfunction

  task automatic model_step(input logic [8:0] c, input bit down, input bit e);
    int d;
    logic [15:0] v;
    int t;
    exp_commit = 1'b0;
    exp_ovf    = 1'b0;
    if (!(e && down) || c[8]) return;
    d = digit_of(c);
    if (d >= 0) begin
      if (m_show || mq.size() == 0) begin
        mq.delete();
        mq.push_back(d);
        m_show = 1'b0;
      end else if (mq.size() < 4) begin
        mq.push_back(d);
      end else begin
        exp_ovf = 1'b1;
      end
    end else if (c[7:0] == 8'h66) begin
      if (!m_show && mq.size() > 0) void'(mq.pop_back());
    end else if (c[7:0] == 8'h76) begin
      mq.delete();
      m_show = 1'b0;
    end else if (c[7:0] == 8'h29) begin
      if (!m_show && mq.size() > 0) begin
        v = 16'h0000;
        foreach (mq[i]) begin
          t = mq[i];
          v = {v[11:0], t[3:0]};
        end
        m_value    = v;
        exp_commit = 1'b1;
        m_show     = 1'b1;
      end
    end
  endtask

  // Drive one decoder event; returns at the falling edge after the DUT sampled it
  task automatic send(input logic [8:0] c, input bit down, input bit e);
    @(negedge clk);
    en           = e;
    key_down[c]  = down;
    last_change  = c;
    key_valid    = 1'b1;
    model_step(c, down, e);
    @(negedge clk);
    key_valid    = 1'b0;
    en           = 1'b1;
  endtask

  task automatic press(input logic [8:0] c);
    send(c, 1'b1, 1'b1);
    send(c, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    key_valid = 1'b0;
    key_down  = '0;
    mq.delete();
    m_show    = 1'b0;
    m_value   = 16'h0000;
    @(negedge clk);
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (nums !== 16'hFFFF) begin failures++; $display("FAIL reset_nums got=%h want=ffff", nums); end
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL reset_value got=%h want=0000", value); end
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL reset_commit got=%b want=0", commit); end
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", digit_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    $display("test_reset: nums=%h value=%h count=%0d", nums, value, digit_count);
  endtask

  task automatic test_press_release();
    do_reset();
    send(kp(1), 1'b1, 1'b1);
    checks++; if (nums !== 16'hFFF1) begin failures++; $display("FAIL press1_nums got=%h want=fff1", nums); end
    checks++; if (digit_count !== 3'd1) begin failures++; $display("FAIL press1_count got=%0d want=1", digit_count); end
    send(kp(1), 1'b0, 1'b1);
    checks++; if (nums !== 16'hFFF1) begin failures++; $display("FAIL release1_nums got=%h want=fff1", nums); end
    send(kp(2), 1'b1, 1'b1);
    checks++; if (nums !== 16'hFF12) begin failures++; $display("FAIL press2_nums got=%h want=ff12", nums); end
    checks++; if (digit_count !== 3'd2) begin failures++; $display("FAIL press2_count got=%0d want=2", digit_count); end
    send(kp(2), 1'b0, 1'b1);
    checks++; if (digit_count !== 3'd2) begin failures++; $display("FAIL release2_count got=%0d want=2", digit_count); end
    $display("test_press_release: nums=%h count=%0d", nums, digit_count);
  endtask

  task automatic test_overflow();
    do_reset();
    press(kp(5)); press(kp(0)); press(kp(3)); press(kp(7));
    checks++; if (nums !== 16'h5037) begin failures++; $display("FAIL full_nums got=%h want=5037", nums); end
    checks++; if (digit_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d want=4", digit_count); end
    send(kp(9), 1'b1, 1'b1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
    checks++; if (nums !== 16'h5037) begin failures++; $display("FAIL ovf_nums got=%h want=5037", nums); end
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    send(kp(9), 1'b0, 1'b1);
    $display("test_overflow: nums=%h count=%0d", nums, digit_count);
  endtask

  task automatic test_commit();
    do_reset();
    press(kp(4)); press(kp(2));
    send(kp(2) & 9'h000 | {1'b0, 8'h29}, 1'b1, 1'b1);
    checks++; if (commit !== 1'b1) begin failures++; $display("FAIL commit_pulse got=%b want=1", commit); end
    checks++; if (value !== 16'h0042) begin failures++; $display("FAIL commit_value got=%h want=0042", value); end
    checks++; if (nums !== 16'hFF42) begin failures++; $display("FAIL commit_nums got=%h want=ff42", nums); end
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL commit_count got=%0d want=0", digit_count); end
    @(negedge clk);
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL commit_clear got=%b want=0", commit); end
    send({1'b0, 8'h29}, 1'b0, 1'b1);
    send(kp(8), 1'b1, 1'b1);
    checks++; if (nums !== 16'hFFF8) begin failures++; $display("FAIL show_digit_nums got=%h want=fff8", nums); end
    checks++; if (value !== 16'h0042) begin failures++; $display("FAIL show_digit_value got=%h want=0042", value); end
    send(kp(8), 1'b0, 1'b1);
    $display("test_commit: value=%h nums=%h", value, nums);
  endtask

  task automatic test_backspace();
    do_reset();
    press(kp(1)); press(kp(2)); press(kp(3));
    press({1'b0, 8'h66});
    checks++; if (nums !== 16'hFF12) begin failures++; $display("FAIL bksp1_nums got=%h want=ff12", nums); end
    press({1'b0, 8'h66});
    checks++; if (nums !== 16'hFFF1) begin failures++; $display("FAIL bksp2_nums got=%h want=fff1", nums); end
    checks++; if (digit_count !== 3'd1) begin failures++; $display("FAIL bksp2_count got=%0d want=1", digit_count); end
    press({1'b0, 8'h66});
    checks++; if (nums !== 16'hFFFF) begin failures++; $display("FAIL bksp3_nums got=%h want=ffff", nums); end
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL bksp3_count got=%0d want=0", digit_count); end
    send({1'b0, 8'h29}, 1'b1, 1'b1);
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL empty_space_commit got=%b want=0", commit); end
    send({1'b0, 8'h29}, 1'b0, 1'b1);
    $display("test_backspace: nums=%h count=%0d", nums, digit_count);
  endtask

  task automatic test_ignored();
    do_reset();
    press(kp(1));
    send({1'b1, 8'h70}, 1'b1, 1'b1);
    checks++; if (nums !== 16'hFFF1) begin failures++; $display("FAIL extended_nums got=%h want=fff1", nums); end
    send({1'b1, 8'h70}, 1'b0, 1'b1);
    send(kp(5), 1'b1, 1'b0);
    checks++; if (nums !== 16'hFFF1) begin failures++; $display("FAIL en_low_nums got=%h want=fff1", nums); end
    checks++; if (digit_count !== 3'd1) begin failures++; $display("FAIL en_low_count got=%0d want=1", digit_count); end
    send(kp(5), 1'b0, 1'b1);
    $display("test_ignored: nums=%h count=%0d", nums, digit_count);
  endtask

  task automatic test_rst_mid_entry();
    do_reset();
    press(kp(4)); press(kp(2)); press({1'b0, 8'h29});
    press(kp(2)); press(kp(3));
    checks++; if (nums !== 16'hFF23) begin failures++; $display("FAIL pre_rst_nums got=%h want=ff23", nums); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (nums !== 16'hFFFF) begin failures++; $display("FAIL async_rst_nums got=%h want=ffff", nums); end
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL async_rst_value got=%h want=0000", value); end
    checks++; if (digit_count !== 3'd0) begin failures++; $display("FAIL async_rst_count got=%0d want=0", digit_count); end
    do_reset();
    $display("test_rst_mid_entry: nums=%h value=%h", nums, value);
  endtask

  task automatic test_toprow();
    logic [15:0] want;
`ifdef KEYPAD_TOPROW_EN
    want = 16'hFF12;
`else
    want = 16'hFFFF;
`endif
    do_reset();
    press(tr(1)); press(tr(2));
    checks++; if (nums !== want) begin failures++; $display("FAIL toprow_nums got=%h want=%h", nums, want); end
    $display("test_toprow: nums=%h", nums);
  endtask

  task automatic test_random();
    logic [8:0] c;
    bit down;
    bit e;
    int sel;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3, 4: c = kp($urandom_range(0, 9));
        5:             c = tr($urandom_range(0, 9));
        6:             c = {1'b0, 8'h29};
        7, 8:          c = {1'b0, 8'h66};
        9:             c = {1'b0, 8'h76};
        10:            c = 9'($urandom_range(0, 511));
        default:       c = {1'b1, 8'(kp_codes[$urandom_range(0, 9)])};
      endcase
      down = ($urandom_range(0, 3) != 0);
      e    = ($urandom_range(0, 7) != 0);
      send(c, down, e);
      checks++; if (nums !== model_nums()) begin failures++; $display("FAIL rand_nums n=%0d code=%h got=%h want=%h", n, c, nums, model_nums()); end
      checks++; if (value !== m_value) begin failures++; $display("FAIL rand_value n=%0d code=%h got=%h want=%h", n, c, value, m_value); end
      checks++; if (commit !== exp_commit) begin failures++; $display("FAIL rand_commit n=%0d code=%h got=%b want=%b", n, c, commit, exp_commit); end
      checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL rand_overflow n=%0d code=%h got=%b want=%b", n, c, overflow, exp_ovf); end
      checks++; if (digit_count !== model_count()) begin failures++; $display("FAIL rand_count n=%0d code=%h got=%0d want=%0d", n, c, digit_count, model_count()); end
    end
    $display("test_random: 400 events, final nums=%h value=%h", nums, value);
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b1;
    key_valid   = 1'b0;
    last_change = '0;
    key_down    = '0;
    m_show      = 1'b0;
    m_value     = 16'h0000;
    test_reset();
    test_press_release();
    test_overflow();
    test_commit();
    test_backspace();
    test_ignored();
    test_rst_mid_entry();
    test_toprow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
